yoshi_sprite_fetch: RTL

Per-pixel sprite fetch stage feeding `yoshi_color_palette`. It compares the VGA beam position against Yoshi's on-screen position and forms the sprite ROM address. It then registers the returned 4-bit palette index together with a transparency-qualified valid flag for the palette/compositor. Position, facing and walk state are latched once per frame, and the block sequences the 4-frame walk animation.

---
 rtl/yoshi_pkg.sv | 16 +
 rtl/yoshi_anim_ctrl.sv | 67 ++++++
 rtl/yoshi_sprite_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/yoshi_pkg.sv
// Shared constants and types for the Yoshi sprite fetch path.
// Defines sprite geometry defaults, ROM width, transparency and FSM states.
package yoshi_pkg;

    localparam int SPR_W_DEF = 32;
    localparam int SPR_H_DEF = 32;
    localparam int ANIM_FRAMES = 4;
    localparam int ROM_AW = 12;
    localparam logic [3:0] TRANSPARENT_IDX = 4'hF;

    typedef enum logic {
        STAND,
        WALK
    } anim_state_t;

endpackage

// File: rtl/yoshi_anim_ctrl.sv
// Walk animation sequencer: STAND/WALK FSM, per-frame tick, anim_frame.
// Ports: Clk, Reset (async high), frame_start, walking -> anim_frame[1:0].
module yoshi_anim_ctrl
    import yoshi_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       walking,
    output logic [1:0] anim_frame
);

    localparam logic [7:0] TICK_MAX = 8'(ANIM_DIV - 1);

    anim_state_t state;
    anim_state_t state_nx;
    logic [7:0]  tick;
    logic [7:0]  tick_nx;
    logic [1:0]  frame_nx;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= STAND;
            tick       <= '0;
            anim_frame <= '0;
        end else begin
            state      <= state_nx;
            tick       <= tick_nx;
            anim_frame <= frame_nx;
        end
    end

    // The FSM state doubles as the per-frame walking shadow:
    // it only moves on frame_start, sampling the value being latched.
    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        frame_nx = anim_frame;
        if (frame_start) begin
            unique case (state)
                STAND: begin
                    tick_nx  = '0;
                    frame_nx = '0;
                    if (walking)
                        state_nx = WALK;
                end
                WALK: begin
                    if (!walking) begin
                        state_nx = STAND;
                        tick_nx  = '0;
                        frame_nx = '0;
                    end else if (tick == TICK_MAX) begin
                        tick_nx  = '0;
                        // 2-bit counter wraps 3 -> 0
                        frame_nx = anim_frame + 2'd1;
                    end else begin
                        tick_nx = tick + 8'd1;
                    end
                end
                default: state_nx = STAND;
            endcase
        end
    end

endmodule

// File: rtl/yoshi_sprite_fetch.sv
// Per-pixel sprite fetch: hit test, ROM address, transparency-qualified
// palette index, 3-cycle latency, one pixel per clock.
// Ports: Clk, Reset (async high), frame_start, DrawX/DrawY (beam),
//   yoshi_x/yoshi_y/facing_left/walking (latched per frame),
//   rom_addr -> sync ROM -> rom_data, pix_idx/pix_valid to palette.
// Option: YOSHI_MIRROR_EN enables horizontal mirroring via facing_left.
module yoshi_sprite_fetch
    import yoshi_pkg::*;
#(
    parameter int SPR_W    = SPR_W_DEF,
    parameter int SPR_H    = SPR_H_DEF,
    parameter int ANIM_DIV = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        yoshi_x,
    input  logic [9:0]        yoshi_y,
    input  logic              facing_left,
    input  logic              walking,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_idx,
    output logic              pix_valid
);

    logic [9:0]  x_sh;
    logic [9:0]  y_sh;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [4:0]  col;
    logic [4:0]  row;
    logic        in_box;
    logic        hit_d1;
    logic        hit_d2;
    logic        opaque;
    logic [1:0]  anim_frame;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_sh <= '0;
            y_sh <= '0;
        end else if (frame_start) begin
            x_sh <= yoshi_x;
            y_sh <= yoshi_y;
        end
    end

    // Zero-extended subtraction: bit 10 set means beam is
    // left of / above the sprite, so no wrap-around hits.
    assign dx = {1'b0, DrawX} - {1'b0, x_sh};
    assign dy = {1'b0, DrawY} - {1'b0, y_sh};

    assign in_box = ~dx[10] & ~dy[10]
                  & (dx < 11'(SPR_W))
                  & (dy < 11'(SPR_H));

    assign row = dy[4:0];

`ifdef YOSHI_MIRROR_EN
    logic facing_sh;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            facing_sh <= 1'b0;
        else if (frame_start)
            facing_sh <= facing_left;
    end

    assign col = facing_sh ? 5'(SPR_W - 1) - dx[4:0]
                           : dx[4:0];
`else
    logic unused_facing;

    assign unused_facing = facing_left;
    assign col = dx[4:0];
`endif

    yoshi_anim_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .walking     (walking),
        .anim_frame  (anim_frame)
    );

    // hit_d2 lines up with rom_data (ROM adds one cycle).
    assign opaque = hit_d2 & (rom_data != TRANSPARENT_IDX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr  <= '0;
            hit_d1    <= 1'b0;
            hit_d2    <= 1'b0;
            pix_idx   <= TRANSPARENT_IDX;
            pix_valid <= 1'b0;
        end else begin
            rom_addr  <= {anim_frame, row, col};
            hit_d1    <= in_box;
            hit_d2    <= hit_d1;
            pix_valid <= opaque;
            pix_idx   <= opaque ? rom_data : TRANSPARENT_IDX;
        end
    end

endmodule
